// File: rtl/cgu_enmon.sv
// Clock-enable stream monitor: over a window of clk0en-qualified cycles, counts
// enable pulses, tracks min/max inter-pulse gap and flags too-fast/too-slow streams.
module cgu_enmon #(
  parameter int CW = 16,
  parameter int GW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk0en,
  input  logic          en,
  input  logic          start,
  input  logic [CW-1:0] window,
  input  logic [GW-1:0] gapmin_lmt,
  input  logic [GW-1:0] gapmax_lmt,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] encnt,
  output logic [GW-1:0] gapmin,
  output logic [GW-1:0] gapmax,
  output logic          err_fast,
  output logic          err_slow
);

  typedef enum logic [1:0] {IDLE, MEAS, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wincnt_q, wincnt_d;
  logic [GW-1:0] gapcnt_q, gapcnt_d;
  logic          seen_q, seen_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] encnt_q, encnt_d;
  logic [GW-1:0] gapmin_q, gapmin_d;
  logic [GW-1:0] gapmax_q, gapmax_d;
  logic          err_fast_q, err_fast_d;
  logic          err_slow_q, err_slow_d;
  logic [GW-1:0] gap;

  always_comb begin
    state_d    = state_q;
    wincnt_d   = wincnt_q;
    gapcnt_d   = gapcnt_q;
    seen_d     = seen_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    encnt_d    = encnt_q;
    gapmin_d   = gapmin_q;
    gapmax_d   = gapmax_q;
    err_fast_d = err_fast_q;
    err_slow_d = err_slow_q;
    gap        = (gapcnt_q == '1) ? gapcnt_q : gapcnt_q + GW'(1);

    // start wins in every state; a zero window aborts to IDLE without done
    if (start) begin
      if (window != '0) begin
        state_d    = MEAS;
        busy_d     = 1'b1;
        wincnt_d   = window;
        encnt_d    = '0;
        gapmax_d   = '0;
        gapmin_d   = '1;
        gapcnt_d   = '0;
        seen_d     = 1'b0;
        err_fast_d = 1'b0;
        err_slow_d = 1'b0;
      end else begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    end else begin
      case (state_q)
        MEAS: if (clk0en) begin
          wincnt_d = wincnt_q - CW'(1);
          if (en) begin
            if (encnt_q != '1) encnt_d = encnt_q + CW'(1);
            if (seen_q) begin
              if (gap < gapmin_q) gapmin_d = gap;
              if (gap > gapmax_q) gapmax_d = gap;
            end
            seen_d   = 1'b1;
            gapcnt_d = '0;
          end else if (gapcnt_q != '1) begin
            gapcnt_d = gapcnt_q + GW'(1);
          end
          // flags use the post-update results so they are valid alongside done
          if (wincnt_q == CW'(1)) begin
            state_d    = DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            err_fast_d = (encnt_d >= CW'(2)) && (gapmin_d < gapmin_lmt);
            err_slow_d = (encnt_d < CW'(2)) || (gapmax_d > gapmax_lmt);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wincnt_q   <= '0;
      gapcnt_q   <= '0;
      seen_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      encnt_q    <= '0;
      gapmin_q   <= '1;
      gapmax_q   <= '0;
      err_fast_q <= 1'b0;
      err_slow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wincnt_q   <= wincnt_d;
      gapcnt_q   <= gapcnt_d;
      seen_q     <= seen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      encnt_q    <= encnt_d;
      gapmin_q   <= gapmin_d;
      gapmax_q   <= gapmax_d;
      err_fast_q <= err_fast_d;
      err_slow_q <= err_slow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign encnt    = encnt_q;
  assign gapmin   = gapmin_q;
  assign gapmax   = gapmax_q;
  assign err_fast = err_fast_q;
  assign err_slow = err_slow_q;

endmodule

// File: tb/tb_cgu_enmon.sv
// Scoreboard bench for cgu_enmon: directed enable patterns push expected results,
// a negedge monitor pops and compares whenever done pulses.
module tb_cgu_enmon;

  logic        clk, reset, clk0en, en, start;
  logic [15:0] window;
  logic [7:0]  gapmin_lmt, gapmax_lmt;
  logic        busy, done, err_fast, err_slow;
  logic [15:0] encnt;
  logic [7:0]  gapmin, gapmax;

  cgu_enmon #(.CW(16), .GW(8)) dut (
    .clk(clk), .reset(reset), .clk0en(clk0en), .en(en), .start(start),
    .window(window), .gapmin_lmt(gapmin_lmt), .gapmax_lmt(gapmax_lmt),
    .busy(busy), .done(done), .encnt(encnt), .gapmin(gapmin), .gapmax(gapmax),
    .err_fast(err_fast), .err_slow(err_slow)
  );

  typedef struct {
    int          done_cyc;
    logic [15:0] encnt;
    logic [7:0]  gmin, gmax;
    logic        ef, es;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;
  int   cyc = 0;
  int   issue = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("encnt", {16'd0, encnt}, {16'd0, e.encnt});
        chk("gapmin", {24'd0, gapmin}, {24'd0, e.gmin});
        chk("gapmax", {24'd0, gapmax}, {24'd0, e.gmax});
        chk("err_fast", {31'd0, err_fast}, {31'd0, e.ef});
        chk("err_slow", {31'd0, err_slow}, {31'd0, e.es});
      end
    end
  end

  task automatic do_start(input int w, input int lmin, input int lmax);
    @(posedge clk); #1;
    start = 1'b1; window = 16'(w); gapmin_lmt = 8'(lmin); gapmax_lmt = 8'(lmax);
    en = 1'b0; clk0en = 1'b1;
    issue = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push(input int lat, input int n, input int gmin, input int gmax,
                      input bit ef, input bit es);
    exp_t e;
    e.done_cyc = issue + lat;
    e.encnt = 16'(n); e.gmin = 8'(gmin); e.gmax = 8'(gmax); e.ef = ef; e.es = es;
    sb.push_back(e);
  endtask

  // cycle i is the i-th cycle sampled after start was accepted
  task automatic drive(input int mode, input int n);
    for (int i = 0; i < n; i++) begin
      case (mode)
        0: begin en = 1'b1; clk0en = 1'b1; end
        1: begin en = (i % 4 == 0); clk0en = 1'b1; end
        2: begin clk0en = (i % 2 == 0); en = (i % 2 == 0); end
        3: begin en = 1'b0; clk0en = 1'b1; end
        default: begin en = (i == 0 || i == 301); clk0en = 1'b1; end
      endcase
      @(posedge clk); #1;
    end
    en = 1'b0; clk0en = 1'b1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (sb.size() != 0) begin
      chk({name, "_timeout"}, sb.size(), 32'd0);
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; clk0en = 1'b1; en = 1'b0; start = 1'b0;
    window = '0; gapmin_lmt = '0; gapmax_lmt = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_encnt", {16'd0, encnt}, 32'd0);
    chk("rst_gapmin", {24'd0, gapmin}, 32'd255);
    chk("rst_gapmax", {24'd0, gapmax}, 32'd0);
    chk("rst_errs", {30'd0, err_fast, err_slow}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // constant enable: gap 1 everywhere
    do_start(16, 1, 1); push(17, 16, 1, 1, 0, 0);
    chk("busy_meas", {31'd0, busy}, 32'd1);
    drive(0, 16); drain("const_en");

    // divide-by-4 stream, limit 5 -> too fast
    do_start(64, 5, 8); push(65, 16, 4, 4, 1, 0);
    drive(1, 64); drain("div4");

    // clk0en alternating: unqualified cycles invisible
    do_start(16, 1, 2); push(32, 16, 1, 1, 0, 0);
    drive(2, 32); drain("clk0en_alt");

    // no enables at all
    do_start(10, 1, 8); push(11, 0, 255, 0, 0, 1);
    drive(3, 10); drain("no_en");

    // 300-cycle gap saturates at 255
    do_start(400, 1, 200); push(401, 2, 255, 255, 0, 1);
    drive(4, 400); drain("gap_sat");

    // zero window from IDLE is ignored, results held
    do_start(0, 1, 1);
    repeat (2) @(posedge clk); #1;
    chk("w0_busy", {31'd0, busy}, 32'd0);
    chk("w0_hold_encnt", {16'd0, encnt}, 32'd2);
    chk("w0_hold_gapmax", {24'd0, gapmax}, 32'd255);
    chk("w0_hold_err_slow", {31'd0, err_slow}, 32'd1);

    // restart mid-window: counters cleared, new window timing
    do_start(20, 1, 1);
    drive(0, 5);
    do_start(8, 2, 6); push(9, 2, 4, 4, 0, 0);
    drive(1, 8); drain("restart");

    // zero-window start mid-measurement aborts with no done
    do_start(20, 1, 1);
    drive(0, 3);
    do_start(0, 1, 1);
    #1 chk("abort_busy", {31'd0, busy}, 32'd0);
    repeat (25) @(posedge clk); #1;

    // reset mid-measurement
    do_start(20, 1, 1);
    drive(0, 5);
    reset = 1'b1; #2;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_gapmin", {24'd0, gapmin}, 32'd255);
    chk("midrst_encnt", {16'd0, encnt}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (30) @(posedge clk); #1;
    chk("midrst_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
